// File: rtl/ff_bank_pkg.sv
// Shared definitions for the ff_bank flip-flop array: the mode encoding
// and the SR invalid-request test used by every cell.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // Only SR mode treats a simultaneous 1/1 on both inputs as a forbidden request.
  function automatic logic is_invalid(input logic [1:0] mode, input logic a, input logic b);
    return (mode == MODE_SR) && a && b;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One bit of ff_bank: combinational next-state for D/T/JK/SR behaviour
// plus the per-bit SR invalid-request flag.
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       q_i,
  output logic       qnext_o,
  output logic       invalid_o
);

  always_comb begin
    qnext_o = q_i;
    case (mode_i)
      MODE_D:  qnext_o = a_i;
      MODE_T:  qnext_o = q_i ^ a_i;
      MODE_JK: begin
        case ({a_i, b_i})
          2'b01:   qnext_o = 1'b0;
          2'b10:   qnext_o = 1'b1;
          2'b11:   qnext_o = ~q_i;
          default: qnext_o = q_i;
        endcase
      end
      MODE_SR: begin
        // The illegal 1/1 request leaves the bit untouched.
        case ({a_i, b_i})
          2'b01:   qnext_o = 1'b0;
          2'b10:   qnext_o = 1'b1;
          default: qnext_o = q_i;
        endcase
      end
      default: qnext_o = q_i;
    endcase
  end

  assign invalid_o = is_invalid(mode_i, a_i, b_i);

endmodule

// File: rtl/ff_bank.sv
// Multi-mode flip-flop bank with complementary outputs, change flags and
// sticky SR-invalid detection; the saturating event counter is built only with FFBANK_ERR_CNT_EN.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic [WIDTH-1:0] CHG,
  output logic             ERR
`ifdef FFBANK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] ERR_CNT
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] qNext;
  logic [WIDTH-1:0] invalidBits;
  logic             invalidEvent;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    ff_cell uCell (
      .mode_i    (MODE),
      .a_i       (A[i]),
      .b_i       (B[i]),
      .q_i       (q_q[i]),
      .qnext_o   (qNext[i]),
      .invalid_o (invalidBits[i])
    );
  end

  // Any number of invalid bits on one edge counts as a single event.
  assign invalidEvent = EN & (|invalidBits);

  always_comb begin
    q_d   = EN ? qNext : q_q;
    chg_d = q_d ^ q_q;
    err_d = CLR_ERR ? 1'b0 : (err_q | invalidEvent);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q   <= RESET_VAL;
      chg_q <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      err_q <= err_d;
    end
  end

  assign Q   = q_q;
  assign QN  = ~q_q;
  assign CHG = chg_q;
  assign ERR = err_q;

`ifdef FFBANK_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear takes priority; otherwise count events until all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR_ERR) begin
      cnt_d = '0;
    end else if (invalidEvent && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ERR_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Directed self-checking bench for ff_bank (WIDTH=8, RESET_VAL=A5); counter
// checks are included when FFBANK_ERR_CNT_EN is defined.
module tb_ff_bank;
  import ff_bank_pkg::*;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 8;
  localparam logic [7:0] RVAL  = 8'hA5;

  logic             CLK;
  logic             RST_N;
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] A, B;
  logic             CLR_ERR;
  logic [WIDTH-1:0] Q, QN, CHG;
  logic             ERR;
`ifdef FFBANK_ERR_CNT_EN
  logic [CNT_W-1:0] ERR_CNT;
`endif

  int checks   = 0;
  int failures = 0;

  ff_bank #(.WIDTH(WIDTH), .RESET_VAL(RVAL), .CNT_W(CNT_W)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .MODE    (MODE),
    .A       (A),
    .B       (B),
    .CLR_ERR (CLR_ERR),
    .Q       (Q),
    .QN      (QN),
    .CHG     (CHG),
    .ERR     (ERR)
`ifdef FFBANK_ERR_CNT_EN
    ,
    .ERR_CNT (ERR_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1ns after a rising edge, outputs are observed at the same point.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #12;
    RST_N = 1'b0;
    #1;
    checks++; if (Q !== RVAL) begin failures++; $display("[TB] FAIL reset_q got=%h exp=%h", Q, RVAL); end
    checks++; if (QN !== 8'h5A) begin failures++; $display("[TB] FAIL reset_qn got=%h exp=%h", QN, 8'h5A); end
    checks++; if (CHG !== 8'h00) begin failures++; $display("[TB] FAIL reset_chg got=%h exp=%h", CHG, 8'h00); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", ERR); end
`ifdef FFBANK_ERR_CNT_EN
    checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", ERR_CNT); end
`endif
    EN = 1'b1; MODE = MODE_D; A = 8'hFF;
    tick();
    checks++; if (Q !== RVAL) begin failures++; $display("[TB] FAIL reset_hold_q got=%h exp=%h", Q, RVAL); end
    RST_N = 1'b1; EN = 1'b0;
  endtask

  task automatic test_d_mode();
    EN = 1'b1; MODE = MODE_D; A = 8'h3C; B = 8'h00;
    tick();
    checks++; if (Q !== 8'h3C) begin failures++; $display("[TB] FAIL d_q got=%h exp=%h", Q, 8'h3C); end
    checks++; if (QN !== 8'hC3) begin failures++; $display("[TB] FAIL d_qn got=%h exp=%h", QN, 8'hC3); end
    checks++; if (CHG !== 8'h99) begin failures++; $display("[TB] FAIL d_chg got=%h exp=%h", CHG, 8'h99); end
    EN = 1'b0; A = 8'hFF;
    tick();
    checks++; if (Q !== 8'h3C) begin failures++; $display("[TB] FAIL d_hold_q got=%h exp=%h", Q, 8'h3C); end
    checks++; if (CHG !== 8'h00) begin failures++; $display("[TB] FAIL d_hold_chg got=%h exp=%h", CHG, 8'h00); end
  endtask

  task automatic test_t_mode();
    logic [7:0] expQ [3];
    expQ[0] = 8'h0F; expQ[1] = 8'h00; expQ[2] = 8'h0F;
    EN = 1'b1; MODE = MODE_D; A = 8'h00;
    tick();
    MODE = MODE_T; A = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Q !== expQ[i]) begin failures++; $display("[TB] FAIL t_q[%0d] got=%h exp=%h", i, Q, expQ[i]); end
      checks++; if (CHG !== 8'h0F) begin failures++; $display("[TB] FAIL t_chg[%0d] got=%h exp=%h", i, CHG, 8'h0F); end
    end
  endtask

  task automatic test_jk_mode();
    EN = 1'b1; MODE = MODE_D; A = 8'hF0;
    tick();
    MODE = MODE_JK; A = 8'hCC; B = 8'hAA;
    tick();
    // Bits 7..0 from Q=F0: toggle,set,reset,hold,toggle,set,reset,hold.
    checks++; if (Q !== 8'h5C) begin failures++; $display("[TB] FAIL jk_q got=%h exp=%h", Q, 8'h5C); end
    checks++; if (CHG !== 8'hAC) begin failures++; $display("[TB] FAIL jk_chg got=%h exp=%h", CHG, 8'hAC); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("[TB] FAIL jk_err got=%b exp=0", ERR); end
  endtask

  task automatic test_sr_mode();
    EN = 1'b1; MODE = MODE_D; A = 8'h00; B = 8'h00;
    tick();
    MODE = MODE_SR; A = 8'h81; B = 8'h01;
    tick();
    checks++; if (Q !== 8'h80) begin failures++; $display("[TB] FAIL sr_q got=%h exp=%h", Q, 8'h80); end
    checks++; if (CHG !== 8'h80) begin failures++; $display("[TB] FAIL sr_chg got=%h exp=%h", CHG, 8'h80); end
    checks++; if (ERR !== 1'b1) begin failures++; $display("[TB] FAIL sr_err got=%b exp=1", ERR); end
`ifdef FFBANK_ERR_CNT_EN
    checks++; if (ERR_CNT !== 8'd1) begin failures++; $display("[TB] FAIL sr_cnt1 got=%0d exp=1", ERR_CNT); end
`endif
    A = 8'h01; B = 8'h01;
    for (int i = 0; i < 253; i++) tick();
`ifdef FFBANK_ERR_CNT_EN
    checks++; if (ERR_CNT !== 8'd254) begin failures++; $display("[TB] FAIL sr_cnt254 got=%0d exp=254", ERR_CNT); end
`endif
    tick();
`ifdef FFBANK_ERR_CNT_EN
    checks++; if (ERR_CNT !== 8'd255) begin failures++; $display("[TB] FAIL sr_cnt255 got=%0d exp=255", ERR_CNT); end
`endif
    for (int i = 0; i < 46; i++) tick();
    checks++; if (Q !== 8'h80) begin failures++; $display("[TB] FAIL sr_invalid_hold_q got=%h exp=%h", Q, 8'h80); end
    checks++; if (ERR !== 1'b1) begin failures++; $display("[TB] FAIL sr_err_sticky got=%b exp=1", ERR); end
`ifdef FFBANK_ERR_CNT_EN
    checks++; if (ERR_CNT !== 8'd255) begin failures++; $display("[TB] FAIL sr_cnt_sat got=%0d exp=255", ERR_CNT); end
`endif
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checks++; if (ERR !== 1'b0) begin failures++; $display("[TB] FAIL sr_clr_err got=%b exp=0", ERR); end
`ifdef FFBANK_ERR_CNT_EN
    checks++; if (ERR_CNT !== 8'd0) begin failures++; $display("[TB] FAIL sr_clr_cnt got=%0d exp=0", ERR_CNT); end
`endif
  endtask

  task automatic test_err_gating();
    EN = 1'b0; MODE = MODE_SR; A = 8'hFF; B = 8'hFF;
    tick();
    checks++; if (ERR !== 1'b0) begin failures++; $display("[TB] FAIL gate_en0_err got=%b exp=0", ERR); end
    EN = 1'b1;
    tick();
    checks++; if (ERR !== 1'b1) begin failures++; $display("[TB] FAIL gate_en1_err got=%b exp=1", ERR); end
    EN = 1'b0; CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checks++; if (ERR !== 1'b0) begin failures++; $display("[TB] FAIL gate_clr_en0 got=%b exp=0", ERR); end
    checks++; if (Q !== 8'h80) begin failures++; $display("[TB] FAIL gate_q got=%h exp=%h", Q, 8'h80); end
  endtask

  task automatic test_async_reset();
    EN = 1'b1; MODE = MODE_SR; A = 8'h7F; B = 8'h01;
    tick();
    checks++; if (Q !== 8'hFE) begin failures++; $display("[TB] FAIL pre_reset_q got=%h exp=%h", Q, 8'hFE); end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (Q !== RVAL) begin failures++; $display("[TB] FAIL async_q got=%h exp=%h", Q, RVAL); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("[TB] FAIL async_err got=%b exp=0", ERR); end
    checks++; if (CHG !== 8'h00) begin failures++; $display("[TB] FAIL async_chg got=%h exp=%h", CHG, 8'h00); end
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b1; EN = 1'b0; MODE = MODE_D; A = '0; B = '0; CLR_ERR = 1'b0;
    test_reset();
    test_d_mode();
    test_t_mode();
    test_jk_mode();
    test_sr_mode();
    test_err_gating();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
